// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b, LSB first) behind a start/done handshake.
// Define SERIAL_SUB_FLAGS_EN to register the zr/ng result flags; otherwise both read 0.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zr,
    output logic             ng
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Only WIDTH-1 result bits need storing; the last bit goes straight into diff.
    logic [WIDTH-2:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             borrow;

    logic             x;
    logic             y;
    logic             d;
    logic             borrow_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last;

    // NOTE: every signal is assigned unconditionally here, so no latch can be inferred.
    always_comb begin
        x          = a_sr[0];
        y          = b_sr[0];
        d          = x ^ y ^ borrow;
        borrow_nxt = (~x & y) | (~(x ^ y) & borrow);
        res_nxt    = {d, res_sr};
        last       = (cnt == CNT_W'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zr         <= 1'b0;
            ng         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt[WIDTH-1:1];
                    borrow <= borrow_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        diff       <= res_nxt;
                        borrow_out <= borrow_nxt;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                        zr         <= (res_nxt == '0);
                        ng         <= res_nxt[WIDTH-1];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SERIAL_SUB_FLAGS_EN
    assign zr = 1'b0;
    assign ng = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized start/operand/reset traffic.
`timescale 1ns/1ps
module tb_serial_subtractor;
    localparam int WIDTH = 16;
`ifdef SERIAL_SUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zr;
    logic             ng;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zr         (zr),
        .ng         (ng)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return x - y;
    endfunction

    // Transaction-level model: an accepted op finishes WIDTH edges later with plain arithmetic.
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic             m_bo   = 1'b0;
    logic             m_zr   = 1'b0;
    logic             m_ng   = 1'b0;
    logic [WIDTH-1:0] m_diff = '0;
    logic [WIDTH-1:0] m_a    = '0;
    logic [WIDTH-1:0] m_b    = '0;
    int               m_left = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_bo   <= 1'b0;
            m_zr   <= 1'b0;
            m_ng   <= 1'b0;
            m_diff <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_diff <= sub_mod(m_a, m_b);
                    m_bo   <= (m_a < m_b);
                    m_zr   <= FLAGS && (m_a == m_b);
                    m_ng   <= FLAGS && sub_mod(m_a, m_b)[WIDTH-1];
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_a    <= a;
                m_b    <= b;
                m_left <= WIDTH;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_diff", 32'(diff), 32'(m_diff));
            check("cyc_borrow", 32'(borrow_out), 32'(m_bo));
            check("cyc_zr", 32'(zr), 32'(m_zr));
            check("cyc_ng", 32'(ng), 32'(m_ng));
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic [WIDTH-1:0] e_diff, input bit e_bo, input bit e_zr,
                          input bit e_ng, input string name);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        lat      = -1;
        busy_cnt = 0;
        for (int k = 0; k < 3 * WIDTH; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        check({name, "_latency"}, lat, WIDTH);
        check({name, "_busy_cycles"}, busy_cnt, WIDTH);
        check({name, "_busy_in_done"}, 32'(busy), 0);
        check({name, "_diff"}, 32'(diff), 32'(e_diff));
        check({name, "_borrow"}, 32'(borrow_out), 32'(e_bo));
        check({name, "_zr"}, 32'(zr), 32'(FLAGS && e_zr));
        check({name, "_ng"}, 32'(ng), 32'(FLAGS && e_ng));
    endtask

    initial begin
        int first;
        int second;
        int done_cnt;
        int low_cnt;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_diff", 32'(diff), 0);
        check("rst_borrow", 32'(borrow_out), 0);
        check("rst_zr", 32'(zr), 0);
        check("rst_ng", 32'(ng), 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, "small_pos");
        run_op(16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1, "negative");
        run_op(16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, "equal");
        run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, "ovf_bound");

        // Held start: op2 is presented during op1's DONE cycle and accepted on its exit edge.
        @(negedge clk);
        start    = 1'b1;
        a        = 16'h0010;
        b        = 16'h0001;
        first    = -1;
        second   = -1;
        low_cnt  = 0;
        for (int k = 0; k < 3 * WIDTH + 4; k++) begin
            @(negedge clk);
            if (!busy) low_cnt++;
            if (done) begin
                if (first < 0) begin
                    first = k;
                    check("b2b_diff1", 32'(diff), 32'h000F);
                    a = 16'h0000;
                    b = 16'h0000;
                end else begin
                    second = k;
                    check("b2b_diff2", 32'(diff), 32'h0000);
                    check("b2b_zr2", 32'(zr), 32'(FLAGS));
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first", first, WIDTH);
        check("b2b_gap", second - first, WIDTH + 1);
        check("b2b_busy_low", low_cnt, 2);

        // Start while busy is ignored, and operand changes after acceptance have no effect.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h00FF;
        b     = 16'h000F;
        @(negedge clk);
        start    = 1'b0;
        first    = -1;
        done_cnt = 0;
        for (int k = 0; k < 2 * WIDTH + 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 5) begin
                start = 1'b1;
                a     = 16'h0000;
                b     = 16'h0001;
            end
            if (k == 6) begin
                start = 1'b0;
                a     = 16'hAAAA;
                b     = 16'h5555;
            end
            if (done) begin
                done_cnt++;
                if (first < 0) begin
                    first = k;
                    check("busy_start_diff", 32'(diff), 32'h00F0);
                end
            end
        end
        check("busy_start_when", first, WIDTH);
        check("busy_start_count", done_cnt, 1);

        // Reset in the middle of a run clears outputs at once and suppresses done.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h7777;
        b     = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_diff", 32'(diff), 0);
        check("midrst_borrow", 32'(borrow_out), 0);
        check("midrst_zr", 32'(zr), 0);
        check("midrst_ng", 32'(ng), 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("midrst_quiet", done_cnt, 0);
        run_op(16'h0002, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, "after_rst");

        // Randomized traffic with boundary operands mixed in and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #2;
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       a = '1;
                2:       a = 16'h8000;
                default: a = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = a;
                2:       b = '1;
                default: b = WIDTH'($urandom);
            endcase
            reset = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        #2;
        start = 1'b0;
        reset = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
